custom_span_search_unit: RTL

Parametrised successor to the fixed 512×16 span search engine. Scans a window of a read-only on-chip memory and reports the longest contiguous subarray that meets one of two selectable criteria:
- exact span: max − min == length − 1
- bounded spread: max − min ≤ threshold

It sits between the Nios-facing control registers and a synchronous RAM port. The base address and element count are configurable, read latency is a parameter, and both loops exit early.

---
 rtl/custom_span_search_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/custom_span_search_unit.sv
// Longest-contiguous-subarray search over a window of a synchronous read-only RAM.
// Criterion is either exact span (max-min == len-1) or bounded spread (max-min <= threshold).
module custom_span_search_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] threshold,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_elem,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] address,
    output logic              write_enable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] start_pos,
    output logic [ADDR_W:0]   length
);
    localparam int CMP_W = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  ONE       = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_I, WAIT_I, CAPT_I, LOAD_J, WAIT_J, EVAL_J, DONE
    } state_t;

    state_t            state;
    logic              mode_r;
    logic [DATA_W-1:0] thr_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   i_r;
    logic [ADDR_W:0]   j_r;
    logic [DATA_W-1:0] min_r;
    logic [DATA_W-1:0] max_r;
    logic [ADDR_W-1:0] best_pos;
    logic [ADDR_W:0]   best_len;
    logic [CNT_W-1:0]  wait_cnt;
    logic              short_pend;

    logic [ADDR_W:0]   n_clamped;
    logic              start_ok;
    logic [DATA_W-1:0] new_min;
    logic [DATA_W-1:0] new_max;
    logic [CMP_W-1:0]  spread;
    logic [CMP_W-1:0]  span;
    logic [CMP_W-1:0]  room;
    logic [CMP_W-1:0]  thr_ext;
    logic              hit;
    logic              inner_brk;
    logic              outer_done;
    logic [ADDR_W:0]   run_len;
    logic [ADDR_W:0]   i_inc;
    logic [ADDR_W:0]   j_inc;
    logic [ADDR_W:0]   j_first;
    logic [ADDR_W-1:0] best_pos_nx;
    logic [ADDR_W:0]   best_len_nx;

    assign write_enable = 1'b0;
    assign n_clamped    = (num_elem > DEPTH) ? DEPTH : num_elem;
    assign start_ok     = start && (state == IDLE || state == DONE);

    // Evaluation datapath for EVAL_J; spread is taken on the already-updated min/max.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        new_min     = (read_data < min_r) ? read_data : min_r;
        new_max     = (read_data > max_r) ? read_data : max_r;
        spread      = CMP_W'(new_max - new_min);
        span        = CMP_W'(j_r - i_r);
        room        = CMP_W'(n_r - ONE - i_r);
        thr_ext     = CMP_W'(thr_r);
        hit         = mode_r ? (spread <= thr_ext) : (spread == span);
        run_len     = j_r - i_r + ONE;
        i_inc       = i_r + ONE;
        j_inc       = j_r + ONE;
        j_first     = i_r + ONE;
        best_pos_nx = best_pos;
        best_len_nx = best_len;
        if (hit && run_len > best_len) begin
            best_pos_nx = i_r[ADDR_W-1:0];
            best_len_nx = run_len;
        end
        // Spread only grows with j, so once past the limit no later j can hit.
        inner_brk  = (j_inc == n_r) || (mode_r ? (spread > thr_ext) : (spread > room));
        outer_done = (i_inc >= n_r - ONE) || (best_len_nx >= n_r - i_inc);
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            thr_r      <= '0;
            base_r     <= '0;
            n_r        <= '0;
            i_r        <= '0;
            j_r        <= '0;
            min_r      <= '0;
            max_r      <= '0;
            best_pos   <= '0;
            best_len   <= '0;
            wait_cnt   <= '0;
            short_pend <= 1'b0;
            address    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_pos  <= '0;
            length     <= '0;
        end else if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            short_pend <= 1'b0;
        end else if (start_ok) begin
            mode_r   <= mode;
            thr_r    <= threshold;
            base_r   <= base_addr;
            n_r      <= n_clamped;
            i_r      <= '0;
            best_pos <= '0;
            best_len <= (n_clamped == '0) ? '0 : ONE;
            done     <= 1'b0;
            if (n_clamped <= ONE) begin
                // Trivial count: one idle cycle, then DONE without ever touching memory.
                state      <= IDLE;
                short_pend <= 1'b1;
            end else begin
                state   <= LOAD_I;
                busy    <= 1'b1;
                address <= base_addr;
            end
        end else if (short_pend) begin
            short_pend <= 1'b0;
            state      <= DONE;
            done       <= 1'b1;
            start_pos  <= best_pos;
            length     <= best_len;
        end else begin
            case (state)
                LOAD_I: begin
                    state    <= WAIT_I;
                    wait_cnt <= WAIT_INIT;
                end
                WAIT_I: begin
                    if (wait_cnt == '0) state <= CAPT_I;
                    else wait_cnt <= wait_cnt - CNT_W'(1);
                end
                CAPT_I: begin
                    min_r   <= read_data;
                    max_r   <= read_data;
                    j_r     <= j_first;
                    address <= base_r + j_first[ADDR_W-1:0];
                    state   <= LOAD_J;
                end
                LOAD_J: begin
                    state    <= WAIT_J;
                    wait_cnt <= WAIT_INIT;
                end
                WAIT_J: begin
                    if (wait_cnt == '0) state <= EVAL_J;
                    else wait_cnt <= wait_cnt - CNT_W'(1);
                end
                EVAL_J: begin
                    min_r    <= new_min;
                    max_r    <= new_max;
                    best_pos <= best_pos_nx;
                    best_len <= best_len_nx;
                    if (inner_brk) begin
                        i_r <= i_inc;
                        if (outer_done) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            start_pos <= best_pos_nx;
                            length    <= best_len_nx;
                        end else begin
                            state   <= LOAD_I;
                            address <= base_r + i_inc[ADDR_W-1:0];
                        end
                    end else begin
                        j_r     <= j_inc;
                        address <= base_r + j_inc[ADDR_W-1:0];
                        state   <= LOAD_J;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
